// File: rtl/risc_seq_pkg.sv
// ----------------------------------------------------------------------------
// risc_seq_pkg
// Shared definitions for the multi-cycle instruction sequencer:
//   - state_t      : FSM state encoding, also exported on state_o for debug
//   - CF_*         : bit positions of the latched decoder control flags
//   - MEM_TIMEOUT_DEF : default number of cycles a memory request may wait
// ----------------------------------------------------------------------------
package risc_seq_pkg;

    // Default memory wait budget before the sequencer gives up and faults.
    localparam int MEM_TIMEOUT_DEF = 16;

    // Sequencer states. FETCH covers both the idle and the requesting phase;
    // the difference is carried by the registered imem_req output.
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    // Bit positions of the control flags captured from the decoder.
    localparam int CF_RW = 0;   // instruction writes the register file
    localparam int CF_RD = 1;   // instruction is a load
    localparam int CF_WR = 2;   // instruction is a store
    localparam int CF_W  = 3;   // number of control flags

endpackage

// File: rtl/mem_wait_timer.sv
// ----------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles spent waiting for a memory acknowledge.
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   clear    in  restart the count at zero (no request outstanding)
//   tick     in  one more cycle spent waiting without an acknowledge
//   expired  out count has reached MEM_TIMEOUT-1 (last cycle an ack may land)
// ----------------------------------------------------------------------------
module mem_wait_timer
    import risc_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int            W    = $clog2(MEM_TIMEOUT);
    localparam logic [W-1:0]  LAST = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] count;

    // The count holds at LAST rather than wrapping; the sequencer leaves the
    // waiting state on that cycle anyway, so holding just keeps expired stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/instr_sequencer.sv
// ----------------------------------------------------------------------------
// instr_sequencer
// Multi-cycle control FSM: fetch, decode, execute, memory, writeback.
//   clk, reset_n        clock and asynchronous active-low reset
//   run                 permission to start a new instruction fetch
//   imem_req/imem_ack   instruction memory handshake
//   ir_en               load instruction register (pulse)
//   dec_*               decoder outputs: register write, load, store
//   ctrl_en             latch decoder control word in the datapath (pulse)
//   dmem_rd/dmem_wr     data memory requests, held until dmem_ack
//   rf_we               register-file write enable (pulse)
//   pc_en               PC update / retire (pulse)
//   state_o             current state encoding (debug)
//   retired             count of retired instructions (wraps)
//   fault               sticky fault flag, cleared only by reset
// All outputs are registered: each strobe is high in the cycle after the
// state that decided it.
// ----------------------------------------------------------------------------
module instr_sequencer
    import risc_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_en,
    input  logic             dec_reg_write,
    input  logic             dec_data_read,
    input  logic             dec_data_write,
    output logic             ctrl_en,
    output logic             dmem_rd,
    output logic             dmem_wr,
    input  logic             dmem_ack,
    output logic             rf_we,
    output logic             pc_en,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired,
    output logic             fault
);

    state_t            state;
    state_t            state_nxt;
    logic [CF_W-1:0]   flags;

    logic imem_req_nxt;
    logic ir_en_nxt;
    logic ctrl_en_nxt;
    logic dmem_rd_nxt;
    logic dmem_wr_nxt;
    logic rf_we_nxt;
    logic pc_en_nxt;
    logic fault_nxt;

    logic waiting;
    logic cur_ack;
    logic tmr_clear;
    logic tmr_tick;
    logic tmr_expired;

    // A request is outstanding while FETCH has issued imem_req or while in
    // MEM. The timer restarts whenever nothing is outstanding, so it always
    // reads zero in the first cycle of a new request.
    always_comb begin
        waiting   = ((state == S_FETCH) && imem_req) || (state == S_MEM);
        cur_ack   = (state == S_FETCH) ? imem_ack : dmem_ack;
        tmr_clear = !waiting;
        tmr_tick  = waiting && !cur_ack;
    end

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (tmr_clear),
        .tick    (tmr_tick),
        .expired (tmr_expired)
    );

    // State register plus every registered output. Decoder flags are
    // captured during DECODE so EXEC and MEM act on a stable copy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_FETCH;
            flags    <= '0;
            imem_req <= 1'b0;
            ir_en    <= 1'b0;
            ctrl_en  <= 1'b0;
            dmem_rd  <= 1'b0;
            dmem_wr  <= 1'b0;
            rf_we    <= 1'b0;
            pc_en    <= 1'b0;
            retired  <= '0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nxt;
            if (state == S_DECODE) begin
                flags[CF_RW] <= dec_reg_write;
                flags[CF_RD] <= dec_data_read;
                flags[CF_WR] <= dec_data_write;
            end
            imem_req <= imem_req_nxt;
            ir_en    <= ir_en_nxt;
            ctrl_en  <= ctrl_en_nxt;
            dmem_rd  <= dmem_rd_nxt;
            dmem_wr  <= dmem_wr_nxt;
            rf_we    <= rf_we_nxt;
            pc_en    <= pc_en_nxt;
            if (pc_en_nxt) begin
                retired <= retired + CNT_W'(1);
            end
            fault    <= fault_nxt;
        end
    end

    // Next-state decisions. Load and store together is an illegal control
    // word and faults straight from EXEC without touching data memory.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (imem_req) begin
                    if (imem_ack) begin
                        state_nxt = S_DECODE;
                    end else if (tmr_expired) begin
                        state_nxt = S_FAULT;
                    end
                end
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                if (flags[CF_RD] && flags[CF_WR]) begin
                    state_nxt = S_FAULT;
                end else if (flags[CF_RD] || flags[CF_WR]) begin
                    state_nxt = S_MEM;
                end else if (flags[CF_RW]) begin
                    state_nxt = S_WB;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_nxt = flags[CF_RD] ? S_WB : S_FETCH;
                end else if (tmr_expired) begin
                    state_nxt = S_FAULT;
                end
            end
            S_WB:    state_nxt = S_FETCH;
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_FAULT;
        endcase
    end

    // Next values of the registered outputs. Requests are held until their
    // ack or until the wait budget runs out; a request is never withdrawn
    // because run drops.
    always_comb begin
        imem_req_nxt = 1'b0;
        ir_en_nxt    = 1'b0;
        ctrl_en_nxt  = 1'b0;
        dmem_rd_nxt  = 1'b0;
        dmem_wr_nxt  = 1'b0;
        rf_we_nxt    = 1'b0;
        pc_en_nxt    = 1'b0;
        case (state)
            S_FETCH: begin
                if (imem_req) begin
                    if (imem_ack) begin
                        ir_en_nxt = 1'b1;
                    end else if (!tmr_expired) begin
                        imem_req_nxt = 1'b1;
                    end
                end else begin
                    imem_req_nxt = run;
                end
            end
            S_DECODE: ctrl_en_nxt = 1'b1;
            S_EXEC: begin
                if (!(flags[CF_RD] && flags[CF_WR])) begin
                    dmem_rd_nxt = flags[CF_RD];
                    dmem_wr_nxt = flags[CF_WR];
                    pc_en_nxt   = !flags[CF_RD] && !flags[CF_WR] && !flags[CF_RW];
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    pc_en_nxt = flags[CF_WR];
                end else if (!tmr_expired) begin
                    dmem_rd_nxt = flags[CF_RD];
                    dmem_wr_nxt = flags[CF_WR];
                end
            end
            S_WB: begin
                rf_we_nxt = 1'b1;
                pc_en_nxt = 1'b1;
            end
            default: ;
        endcase
        fault_nxt = (state_nxt == S_FAULT);
    end

    assign state_o = state;

endmodule

// File: tb/tb_instr_sequencer.sv
// ----------------------------------------------------------------------------
// tb_instr_sequencer
// Randomised instruction stream with a transaction-level scoreboard.
// The driver pushes the expected outcome of each instruction; the monitor
// pops an entry whenever the sequencer retires (pc_en) or raises fault.
// ----------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam int T = 16;

    localparam int K_BR    = 0;
    localparam int K_R     = 1;
    localparam int K_LOAD  = 2;
    localparam int K_STORE = 3;
    localparam int K_ILL   = 4;

    typedef struct {
        int kind;      // 0 = retire, 1 = fault
        int lat;       // cycles from ir_en to pc_en / fault
        int rfw;       // rf_we pulses
        int rdc;       // dmem_rd cycles
        int wrc;       // dmem_wr cycles
        int ret;       // retired value at the end
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic        ir_en;
    logic        dec_reg_write = 1'b0;
    logic        dec_data_read = 1'b0;
    logic        dec_data_write = 1'b0;
    logic        ctrl_en;
    logic        dmem_rd;
    logic        dmem_wr;
    logic        dmem_ack = 1'b0;
    logic        rf_we;
    logic        pc_en;
    logic [2:0]  state_o;
    logic [31:0] retired;
    logic        fault;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   exp_retired = 0;
    exp_t sb[$];

    instr_sequencer #(
        .MEM_TIMEOUT(T),
        .CNT_W(32)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .run            (run),
        .imem_req       (imem_req),
        .imem_ack       (imem_ack),
        .ir_en          (ir_en),
        .dec_reg_write  (dec_reg_write),
        .dec_data_read  (dec_data_read),
        .dec_data_write (dec_data_write),
        .ctrl_en        (ctrl_en),
        .dmem_rd        (dmem_rd),
        .dmem_wr        (dmem_wr),
        .dmem_ack       (dmem_ack),
        .rf_we          (rf_we),
        .pc_en          (pc_en),
        .state_o        (state_o),
        .retired        (retired),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Expected outcome of one instruction. Decision happens two cycles after
    // ir_en (DECODE then EXEC); a memory phase lasts md+1 strobe cycles,
    // capped by the wait budget; loads and R-types spend one more cycle in WB.
    function automatic exp_t refModel(input int kind, input int md);
        exp_t e;
        int   mcyc;
        e.kind = 0; e.rfw = 0; e.rdc = 0; e.wrc = 0; e.lat = 2;
        mcyc = (md < T) ? md + 1 : T;
        case (kind)
            K_R:     begin e.lat = 3; e.rfw = 1; end
            K_LOAD:  begin
                e.rdc = mcyc;
                if (md < T) begin e.lat = 2 + mcyc + 1; e.rfw = 1; end
                else        begin e.lat = 2 + T; e.kind = 1; end
            end
            K_STORE: begin
                e.wrc = mcyc;
                if (md < T) e.lat = 2 + mcyc;
                else begin e.lat = 2 + T; e.kind = 1; end
            end
            K_ILL:   e.kind = 1;
            default: ;
        endcase
        if (e.kind == 0) exp_retired++;
        e.ret = exp_retired;
        return e;
    endfunction

    task automatic doReset();
        reset_n = 1'b0;
        run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        dec_reg_write = 1'b0; dec_data_read = 1'b0; dec_data_write = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_retired = 0;
    endtask

    // Run one instruction through the handshakes: fd cycles of fetch wait,
    // md cycles of data wait (md >= T withholds the ack entirely). Stray acks
    // for the other memory are sprinkled in while waiting.
    task automatic applyStimulus(input int kind, input int fd, input int md);
        bit seen;
        sb.push_back(refModel(kind, md));
        dec_reg_write  = (kind == K_R) || (kind == K_LOAD);
        dec_data_read  = (kind == K_LOAD) || (kind == K_ILL);
        dec_data_write = (kind == K_STORE) || (kind == K_ILL);
        run = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checkOutput("fetch_req_seen", longint'(seen), 1);
        if (!seen) return;
        for (int i = 0; i < fd; i++) begin
            dmem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        dmem_ack = 1'b0;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        if (kind == K_LOAD || kind == K_STORE) begin
            seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                if (dmem_rd || dmem_wr) begin seen = 1'b1; break; end
                @(negedge clk);
            end
            checkOutput("mem_req_seen", longint'(seen), 1);
            if (seen && md < T) begin
                for (int i = 0; i < md; i++) begin
                    imem_ack = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                imem_ack = 1'b0;
                dmem_ack = 1'b1;
                @(negedge clk);
                dmem_ack = 1'b0;
            end
        end
        seen = 1'b0;
        for (int i = 0; i < 3 * T; i++) begin
            if (pc_en || fault) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checkOutput("retire_seen", longint'(seen), 1);
    endtask

    // Monitor: measures each instruction from its ir_en pulse and compares
    // against the oldest scoreboard entry when it retires or faults.
    int  m_start = 0;
    int  m_rfw = 0, m_rdc = 0, m_wrc = 0, m_cen = 0;
    bit  m_prev_fault = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            m_prev_fault = 1'b0;
        end else begin
            checkOutput("one_request", longint'(int'(imem_req) + int'(dmem_rd) + int'(dmem_wr) <= 1), 1);
            if (ir_en) begin
                m_start = cyc; m_rfw = 0; m_rdc = 0; m_wrc = 0; m_cen = 0;
            end
            if (dmem_rd) m_rdc++;
            if (dmem_wr) m_wrc++;
            if (rf_we)   m_rfw++;
            if (ctrl_en) m_cen++;
            if (pc_en || (fault && !m_prev_fault)) begin
                checkOutput("sb_nonempty", longint'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checkOutput("outcome", longint'(fault ? 1 : 0), e.kind);
                    checkOutput("latency", cyc - m_start, e.lat);
                    checkOutput("rf_we_pulses", m_rfw, e.rfw);
                    checkOutput("dmem_rd_cycles", m_rdc, e.rdc);
                    checkOutput("dmem_wr_cycles", m_wrc, e.wrc);
                    checkOutput("ctrl_en_pulses", m_cen, 1);
                    checkOutput("retired", longint'(retired), e.ret);
                    if (fault) begin
                        checkOutput("fault_strobes", longint'({imem_req, dmem_rd, dmem_wr}), 0);
                        checkOutput("fault_state", longint'(state_o), 5);
                    end
                end
            end
            m_prev_fault = fault;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_state", longint'(state_o), 0);
        checkOutput("rst_outputs", longint'({imem_req, ir_en, ctrl_en, dmem_rd, dmem_wr, rf_we, pc_en, fault}), 0);
        checkOutput("rst_retired", longint'(retired), 0);
        reset_n = 1'b1;

        // Idle with run low: no fetch request
        repeat (4) @(negedge clk);
        checkOutput("idle_no_req", longint'(imem_req), 0);

        // Directed: R-type, load (3 strobe cycles), store, branch
        applyStimulus(K_R, 2, 0);
        applyStimulus(K_LOAD, 1, 2);
        applyStimulus(K_STORE, 0, 1);
        applyStimulus(K_BR, 3, 0);

        // Random stream of legal instructions
        for (int n = 0; n < 40; n++) begin
            applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
        end

        // Ack on the last allowed cycle is accepted
        applyStimulus(K_LOAD, 1, T - 1);
        applyStimulus(K_STORE, 0, T - 1);

        // Request persists after run drops, then async reset clears it
        run = 1'b1;
        for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
        run = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("req_persists", longint'(imem_req), 1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_rst_req", longint'(imem_req), 0);
        checkOutput("async_rst_state", longint'(state_o), 0);
        checkOutput("async_rst_retired", longint'(retired), 0);
        doReset();
        repeat (3) @(negedge clk);
        checkOutput("post_rst_idle", longint'(imem_req), 0);

        // Data memory timeout
        applyStimulus(K_LOAD, 1, T);
        repeat (2) @(negedge clk);
        checkOutput("fault_sticky", longint'(fault), 1);
        doReset();
        checkOutput("fault_cleared", longint'(fault), 0);

        // Illegal control word
        applyStimulus(K_ILL, 0, 0);
        repeat (2) @(negedge clk);
        checkOutput("ill_sticky", longint'(fault), 1);
        doReset();

        // Recovery after reset
        applyStimulus(K_BR, 0, 0);
        repeat (2) @(negedge clk);
        checkOutput("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
